output_frame_packer: RTL and testbench
======================================

# output_frame_packer

Upstream feeder for the output parallel-to-serial stage in the fast-readout output path. Accepts narrow pixel samples over a valid/ready handshake and packs them LSB-first into a WIDTH_INPUT-bit fill buffer. Presents completed frames on a held-stable parallel bus that is swapped only on the serializer's frame boundary. Runs a mirror of the serializer's free-running bit counter, so both blocks must share CLK and RST_N.

## Interface
- WIDTH_INPUT, 128, frame width in bits; must equal the serializer's WIDTH_INPUT.
- SAMPLE_WIDTH, 8, bits per input sample; WIDTH_INPUT must be an integer multiple of it.
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- sample_in  input  SAMPLE_WIDTH  pixel sample from the readout logic.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  block can accept a sample this cycle.
- data_out  output  WIDTH_INPUT  frame to the serializer's data_in; registered.
- frame_loaded  output  1  one-cycle pulse: a new packed frame was loaded onto data_out.
- underrun  output  1  one-cycle pulse: a boundary passed with no complete frame.

## Operation
- Constants: N = WIDTH_INPUT / SAMPLE_WIDTH samples per frame. Bit counter is $clog2(WIDTH_INPUT) bits wide. Sample index is $clog2(N) bits wide, with a minimum of 1 bit.
- Fill buffer
  - A sample is accepted on an edge with sample_valid && sample_ready.
  - An accepted sample is written to fill[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH], and idx is incremented.
  - When the accepted sample has idx == N-1: idx wraps to 0 and full is set.
- sample_ready = RST_N && !full; this is combinational from the registers.
  - While full is set, no samples are accepted and the fill contents are held.
- Mirror counter
  - The counter runs 0 → WIDTH_INPUT-1 → 0 unconditionally, on the same edges and from the same reset as the serializer's bit_select.
- Boundary edge: an active edge where counter == WIDTH_INPUT-1.
  - If full was set before the edge: data_out <= fill, full clears, and frame_loaded = 1 in the following cycle.
  - If full was clear before the edge: data_out <= 0 and underrun = 1 in the following cycle. Any partial fill and idx are kept.
- On non-boundary edges, data_out holds. frame_loaded and underrun are 0.
- Simultaneous events
  - If the last sample of a frame is accepted on a boundary edge, the boundary decision uses the pre-edge value of full, which is 0. Result: underrun, and that frame waits for the next boundary.
  - full clearing on a boundary edge makes sample_ready high in the next cycle. Filling of the next frame therefore overlaps transmission of the current one (double-buffering).
- Reset, including mid-frame: counter, idx and full go to 0; data_out = 0; frame_loaded = 0; underrun = 0; fill contents are don't-care. Partial frames are discarded.

## Timing
- Counter value k corresponds to the serializer sampling data_out[k] on the same edge. data_out changes only on the edge that samples bit WIDTH_INPUT-1, so each frame is stable across all WIDTH_INPUT serializer samples.
- First boundary: the WIDTH_INPUT-th active edge after RST_N goes high. The serializer emits the WIDTH_INPUT bits of the reset value (zeros) before then.
- Latency
  - Last sample accepted at least 1 edge before a boundary: the frame is loaded at that boundary.
  - Its bit 0 appears on the serializer's data_out one edge after the boundary.
  - Its bit k appears k+1 edges after the boundary.
- Sustained throughput: one frame per WIDTH_INPUT cycles. This requires at least N accepted samples per WIDTH_INPUT cycles; otherwise underrun pulses occur.
- Underrun spacing: underrun pulses are exactly WIDTH_INPUT cycles apart while starved.

## Test plan
(All scenarios use WIDTH_INPUT=16, SAMPLE_WIDTH=4, with the serializer instantiated downstream.)
- Reset → data_out=0, sample_ready=0 while RST_N low. After release: sample_ready=1, and the first boundary occurs at the 16th edge with an underrun pulse.
- Basic load: samples 0x1,0x2,0x3,0x4 accepted back-to-back before the first boundary → data_out=0x4321 after the boundary and frame_loaded pulse. Serial stream is the 16 bits of 0x4321 LSB-first: 1,0,0,0,0,1,0,0,1,1,0,0,0,0,1,0.
- Backpressure: present 8 samples continuously → exactly 4 accepted, then sample_ready=0 until the boundary. The remaining 4 are accepted after the boundary and loaded at the next boundary, so consecutive frames differ with no gap.
- Last sample accepted on the boundary edge → underrun pulse at that boundary; the frame loads 16 cycles later with frame_loaded, and sample_ready stays 0 in between.
- Starvation: only 2 samples supplied → underrun every 16 cycles and data_out=0. Supplying the remaining 2 → the frame loads at the next boundary with the original first 2 samples intact.
- Mid-frame reset: assert RST_N low for 1 cycle after 3 samples → all outputs 0. A fresh 4 samples 0xA,0xB,0xC,0xD → data_out=0xDCBA at the 16th edge after release.

Source files
------------

// File: rtl/output_frame_packer.sv
// output_frame_packer
// Packs narrow pixel samples LSB-first into a frame-wide fill buffer and hands
// completed frames to the downstream serializer on its frame boundary. A local
// copy of the serializer's bit counter tells us where that boundary falls, so
// this block must share CLK and RST_N with the serializer.

module output_frame_packer #(
    parameter int WIDTH_INPUT  = 128,
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [WIDTH_INPUT-1:0]  data_out,
    output logic                    frame_loaded,
    output logic                    underrun
);

    localparam int N     = WIDTH_INPUT / SAMPLE_WIDTH;
    localparam int CNT_W = (WIDTH_INPUT > 1) ? $clog2(WIDTH_INPUT) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_INPUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [CNT_W-1:0]       counter_q, counter_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   full_q, full_d;
    logic [WIDTH_INPUT-1:0] fill_q, fill_d;
    logic [WIDTH_INPUT-1:0] data_out_q, data_out_d;
    logic                   frame_loaded_q, frame_loaded_d;
    logic                   underrun_q, underrun_d;

    logic boundary;
    logic accept;

    // Ready is taken straight from the registers so the source sees it early
    // in the cycle; it is forced low while reset is held.
    assign sample_ready = RST_N && !full_q;
    assign accept       = sample_valid && sample_ready;
    assign boundary     = (counter_q == CNT_LAST);

    assign data_out     = data_out_q;
    assign frame_loaded = frame_loaded_q;
    assign underrun     = underrun_q;

    // Free-running mirror of the serializer's bit_select.
    always_comb begin
        counter_d = counter_q + CNT_W'(1);
        if (boundary) begin
            counter_d = '0;
        end
    end

    // Fill side: write the accepted sample at the current slot, advance the
    // slot, and mark the buffer full on the last slot. The boundary clears full
    // using its pre-edge value, so a frame completing on a boundary waits.
    always_comb begin
        fill_d = fill_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (boundary && full_q) begin
            full_d = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    fill_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
                end
            end
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                full_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output side: only the boundary edge may change data_out, either to the
    // completed frame or to zeros when nothing was ready in time.
    always_comb begin
        data_out_d     = data_out_q;
        frame_loaded_d = 1'b0;
        underrun_d     = 1'b0;
        if (boundary) begin
            if (full_q) begin
                data_out_d     = fill_q;
                frame_loaded_d = 1'b1;
            end else begin
                data_out_d = '0;
                underrun_d = 1'b1;
            end
        end
    end

    // Control and output registers; reset discards any partial frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            counter_q      <= '0;
            idx_q          <= '0;
            full_q         <= 1'b0;
            data_out_q     <= '0;
            frame_loaded_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            idx_q          <= idx_d;
            full_q         <= full_d;
            data_out_q     <= data_out_d;
            frame_loaded_q <= frame_loaded_d;
            underrun_q     <= underrun_d;
        end
    end

    // Fill storage needs no reset: slots are always written before full is set.
    always_ff @(posedge CLK) begin
        fill_q <= fill_d;
    end

endmodule

// File: tb/tb_output_frame_packer.sv
// Testbench for output_frame_packer (WIDTH_INPUT=16, SAMPLE_WIDTH=4).
// The driver keeps a transaction-level model (edge count since reset, queue of
// accepted samples, one completed frame slot) and pushes the expected boundary
// outcome into a scoreboard; a monitor pops and compares after each edge.

module tb_output_frame_packer;

    localparam int WI = 16;
    localparam int SW = 4;
    localparam int NS = WI / SW;

    logic          CLK;
    logic          RST_N;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic [WI-1:0] data_out;
    logic          frame_loaded;
    logic          underrun;

    output_frame_packer #(
        .WIDTH_INPUT (WI),
        .SAMPLE_WIDTH(SW)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .data_out    (data_out),
        .frame_loaded(frame_loaded),
        .underrun    (underrun)
    );

    typedef struct {
        bit            is_load;
        logic [WI-1:0] data;
        int            cycle;
    } exp_t;

    exp_t          sb[$];
    logic [SW-1:0] pending[$];
    logic [SW-1:0] m_partial[$];
    bit            m_full;
    logic [WI-1:0] m_frame;
    int            model_edge;
    int            checks;
    int            errors;

    // Clock generation.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single point where every comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advanced once per clock edge.
    task automatic stepModel(input bit rst_n, input bit acc, input logic [SW-1:0] data);
        exp_t e;
        if (!rst_n) begin
            m_partial.delete();
            m_full     = 1'b0;
            model_edge = 0;
        end else begin
            model_edge++;
            if (model_edge % WI == 0) begin
                e.cycle = model_edge;
                if (m_full) begin
                    e.is_load = 1'b1;
                    e.data    = m_frame;
                    m_full    = 1'b0;
                end else begin
                    e.is_load = 1'b0;
                    e.data    = '0;
                end
                sb.push_back(e);
            end
            if (acc) begin
                m_partial.push_back(data);
                if (m_partial.size() == NS) begin
                    m_frame = '0;
                    for (int i = 0; i < NS; i++) begin
                        m_frame = m_frame | (WI'(m_partial[i]) << (i * SW));
                    end
                    m_full = 1'b1;
                    m_partial.delete();
                end
            end
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, check ready, then
    // advance the model on the rising edge.
    task automatic applyStimulus(input bit rst_n, input bit valid, input logic [SW-1:0] data, output bit acc);
        bit exp_ready;
        @(negedge CLK);
        RST_N        = rst_n;
        sample_valid = valid;
        sample_in    = data;
        #1;
        exp_ready = rst_n && !m_full;
        checkOutput("sample_ready", 32'(sample_ready), 32'(exp_ready));
        acc = valid && exp_ready;
        @(posedge CLK);
        stepModel(rst_n, acc, data);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) applyStimulus(1'b1, 1'b0, '0, acc);
    endtask

    // Present queued samples, holding each until accepted, with a cycle budget.
    task automatic sendPending();
        bit acc;
        int guard;
        guard = 0;
        while (pending.size() > 0 && guard < 200) begin
            applyStimulus(1'b1, 1'b1, pending[0], acc);
            if (acc) begin
                void'(pending.pop_front());
            end
            guard++;
        end
        checkOutput("send_timeout", 32'(pending.size()), 32'd0);
        pending.delete();
    endtask

    // Monitor: after every edge, compare pulses and data_out with the scoreboard.
    initial begin : monitor
        bit            r;
        int            edge_num;
        logic [WI-1:0] held;
        exp_t          e;
        edge_num = 0;
        held     = '0;
        forever begin
            @(posedge CLK);
            r = RST_N;
            #1;
            if (!r) begin
                edge_num = 0;
                held     = '0;
                sb.delete();
                checkOutput("reset_data_out", 32'(data_out), 32'd0);
                checkOutput("reset_pulses", 32'({frame_loaded, underrun}), 32'd0);
            end else begin
                edge_num++;
                while (sb.size() > 0 && sb[0].cycle < edge_num) begin
                    e = sb.pop_front();
                    checkOutput("missing_pulse_edge", 32'(edge_num), 32'(e.cycle));
                end
                if (sb.size() > 0 && sb[0].cycle == edge_num) begin
                    e = sb.pop_front();
                    checkOutput("frame_loaded", 32'(frame_loaded), 32'(e.is_load));
                    checkOutput("underrun", 32'(underrun), 32'(!e.is_load));
                    held = e.data;
                end else begin
                    checkOutput("no_pulse", 32'({frame_loaded, underrun}), 32'd0);
                end
                checkOutput("data_out", 32'(data_out), 32'(held));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin : driver
        bit acc;
        int rate;
        int guard;
        checks       = 0;
        errors       = 0;
        model_edge   = 0;
        m_full       = 1'b0;
        m_frame      = '0;
        RST_N        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;

        repeat (3) applyStimulus(1'b0, 1'b0, '0, acc);

        // Basic load of 0x4321 at the first boundary.
        pending = '{4'h1, 4'h2, 4'h3, 4'h4};
        sendPending();
        idle(14);

        // Backpressure: 8 samples presented back to back.
        pending = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        sendPending();
        idle(40);

        // Last sample accepted exactly on a boundary edge.
        guard = 0;
        while (model_edge % WI != WI - NS && guard < 64) begin
            idle(1);
            guard++;
        end
        pending = '{4'hE, 4'h3, 4'h7, 4'h1};
        sendPending();
        idle(40);

        // Starvation: half a frame, wait, then complete it.
        pending = '{4'hF, 4'h9};
        sendPending();
        idle(40);
        pending = '{4'h2, 4'h6};
        sendPending();
        idle(36);

        // Mid-frame reset discards the partial frame.
        pending = '{4'h1, 4'h1, 4'h1};
        sendPending();
        applyStimulus(1'b0, 1'b0, '0, acc);
        pending = '{4'hA, 4'hB, 4'hC, 4'hD};
        sendPending();
        idle(20);

        // Randomized traffic at varying sample rates, with rare resets.
        rate = 100;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) begin
                rate = $urandom_range(10, 100);
            end
            if ($urandom_range(0, 299) == 0) begin
                applyStimulus(1'b0, 1'b0, '0, acc);
            end else begin
                applyStimulus(1'b1, $urandom_range(0, 99) < rate, SW'($urandom), acc);
            end
        end

        idle(20);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
